// File: rtl/ble_crc_appender.sv
// BLE TX framing stage: forwards serial PDU bits and appends the 24-bit CRC, MSB first.
// Optional macro BLE_CRC_APPENDER_PKT_COUNT_EN adds a 16-bit packet counter output.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | waiting for first PDU bit; lfsr tracks crc_init
//  PAYLOAD | forwarding PDU bits, lfsr accumulating CRC
//  CRC     | upstream blocked, shifting lfsr out through output reg
module ble_crc_appender #(
   parameter int unsigned               CRC_WIDTH = 24,
   parameter logic [CRC_WIDTH-1:0]      CRC_POLY  = 24'h00065B
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [CRC_WIDTH-1:0] crc_init,
   input  logic                 s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic                 s_tlast,
   output logic                 m_tdata,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 m_tlast,
   output logic                 busy
`ifdef BLE_CRC_APPENDER_PKT_COUNT_EN
   ,
   output logic [15:0]          pkt_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CRC     = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CRC_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic                 m_tdata_q, m_tdata_d;
   logic                 m_tvalid_q, m_tvalid_d;
   logic                 m_tlast_q, m_tlast_d;
   logic                 out_load;
   logic                 s_tready_c;
   logic                 beat;

   function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c,
                                                     input logic b);
      logic fb;
      fb = b ^ c[CRC_WIDTH-1];
      return {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         lfsr_q     <= crc_init;
         bit_cnt_q  <= '0;
         m_tdata_q  <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         bit_cnt_q  <= bit_cnt_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      bit_cnt_d  = bit_cnt_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;

      out_load   = ~m_tvalid_q | m_tready;
      s_tready_c = (state_q != ST_CRC) && out_load;
      beat       = s_tvalid & s_tready_c;

      // Register drains on handshake unless a new bit is loaded below.
      if (out_load) begin
         m_tvalid_d = 1'b0;
         m_tlast_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            lfsr_d = crc_init;
            if (beat) begin
               m_tdata_d  = s_tdata;
               m_tvalid_d = 1'b1;
               lfsr_d     = crc_step(crc_init, s_tdata);
               bit_cnt_d  = '0;
               state_d    = s_tlast ? ST_CRC : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (beat) begin
               m_tdata_d  = s_tdata;
               m_tvalid_d = 1'b1;
               lfsr_d     = crc_step(lfsr_q, s_tdata);
               if (s_tlast) begin
                  state_d = ST_CRC;
               end
            end
         end
         ST_CRC: begin
            if (out_load) begin
               if (m_tvalid_q && m_tlast_q) begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
               end else begin
                  // Plain shift: the remainder is final, no feedback while emitting.
                  m_tdata_d  = lfsr_q[CRC_WIDTH-1];
                  m_tvalid_d = 1'b1;
                  m_tlast_d  = (bit_cnt_q == 5'd23);
                  lfsr_d     = {lfsr_q[CRC_WIDTH-2:0], 1'b0};
                  bit_cnt_d  = bit_cnt_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign s_tready = s_tready_c;
   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign busy     = (state_q != ST_IDLE) | m_tvalid_q;

`ifdef BLE_CRC_APPENDER_PKT_COUNT_EN
   logic [15:0] pkt_count_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         pkt_count_q <= '0;
      end else if (m_tvalid_q && m_tready && m_tlast_q) begin
         pkt_count_q <= pkt_count_q + 16'd1;
      end
   end

   assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_ble_crc_appender.sv
// Scoreboard bench for ble_crc_appender: directed packets with hand-computed CRCs,
// a negedge monitor pops expected {last,data} per output handshake.
module tb_ble_crc_appender;

   logic        aclk;
   logic        areset;
   logic [23:0] crc_init;
   logic        s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic        m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        busy;
`ifdef BLE_CRC_APPENDER_PKT_COUNT_EN
   logic [15:0] pkt_count;
`endif

   ble_crc_appender dut (
      .aclk     (aclk),
      .areset   (areset),
      .crc_init (crc_init),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tlast  (s_tlast),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .busy     (busy)
`ifdef BLE_CRC_APPENDER_PKT_COUNT_EN
      ,
      .pkt_count(pkt_count)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic [1:0] exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         pops = 0;
   bit         in_reset = 1'b1;
   bit         tog = 1'b0;
   bit         prev_stall = 1'b0;
   logic [1:0] prev_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every output handshake and stability while stalled.
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge aclk);
         if (!in_reset && !areset) begin
            if (m_tvalid && m_tready) begin
               n_chk++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_out: got last=%0b data=%0b with empty scoreboard at %0t",
                           m_tlast, m_tdata, $time);
               end else begin
                  e = exp_q.pop_front();
                  pops++;
                  if ({m_tlast, m_tdata} !== e) begin
                     n_fail++;
                     $display("FAIL out_bit: got last=%0b data=%0b expected last=%0b data=%0b at %0t",
                              m_tlast, m_tdata, e[1], e[0], $time);
                  end
               end
            end
            if (prev_stall && m_tvalid) begin
               n_chk++;
               if ({m_tlast, m_tdata} !== prev_out) begin
                  n_fail++;
                  $display("FAIL stall_stable: got %0b expected %0b at %0t",
                           {m_tlast, m_tdata}, prev_out, $time);
               end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tlast, m_tdata};
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (tog) m_tready = ~m_tready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic send_pkt(input logic [31:0] bits, input int len,
                           input logic [23:0] init, input logic [23:0] init_after,
                           input logic [23:0] crc, input bit gaps, input bit hold,
                           output int first_stall);
      bit ok;
      int t;
      first_stall = 0;
      for (int i = 0; i < len; i++) exp_q.push_back({1'b0, bits[len-1-i]});
      for (int j = 23; j >= 0; j--) exp_q.push_back({(j == 0), crc[j]});
      crc_init = init;
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            s_tvalid = 1'b0;
            s_tdata  = 1'($urandom);
            s_tlast  = 1'($urandom);
            repeat ($urandom_range(0, 2)) begin
               @(posedge aclk);
               #1;
            end
         end
         s_tvalid = 1'b1;
         s_tdata  = bits[len-1-i];
         s_tlast  = (i == len - 1);
         t = 0;
         do begin
            @(negedge aclk);
            ok = s_tready;
            @(posedge aclk);
            #1;
            t++;
            if (!ok && i == 0) first_stall++;
         end while (!ok && t < 300);
         chk("accept_timeout", {31'd0, ok}, 32'd1);
         if (i == 0) crc_init = init_after;
      end
      if (!hold) begin
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || m_tvalid) && t < 1000) begin
         @(posedge aclk);
         #1;
         t++;
      end
      chk("drain_left", exp_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      in_reset = 1'b1;
      areset   = 1'b1;
      exp_q.delete();
      @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   initial begin
      int st;
      int p0;
      int t;
      areset   = 1'b1;
      crc_init = 24'h0;
      s_tdata  = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_m_tdata",  {31'd0, m_tdata},  32'd0);
      chk("rst_m_tlast",  {31'd0, m_tlast},  32'd0);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
`ifdef BLE_CRC_APPENDER_PKT_COUNT_EN
      chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
`endif
      in_reset = 1'b0;
      @(posedge aclk);
      #1;

      // Single '1' from zero preset: CRC equals the polynomial.
      send_pkt(32'h1, 1, 24'h000000, 24'h000000, 24'h00065B, 1'b0, 1'b0, st);
      drain();
      // Preset MSB set, bit '0': feedback fires, same CRC.
      send_pkt(32'h0, 1, 24'h800000, 24'h800000, 24'h00065B, 1'b0, 1'b0, st);
      drain();
      // All zeros stays zero.
      send_pkt(32'h0, 8, 24'h000000, 24'h000000, 24'h000000, 1'b0, 1'b0, st);
      drain();
      // Two-bit packets: 1,0 -> 0x000CB6 ; 1,1 -> 0x000AED.
      send_pkt(32'h2, 2, 24'h000000, 24'h000000, 24'h000CB6, 1'b0, 1'b0, st);
      drain();
      send_pkt(32'h3, 2, 24'h000000, 24'h000000, 24'h000AED, 1'b0, 1'b0, st);
      drain();
      // Advertising preset, 0,0 -> 0x55530F; crc_init changed after first beat is ignored.
      send_pkt(32'h0, 2, 24'h555555, 24'h123456, 24'h55530F, 1'b0, 1'b0, st);
      drain();

      // Toggling m_tready and random s_tvalid gaps.
      tog = 1'b1;
      send_pkt(32'h1, 1, 24'h000000, 24'h000000, 24'h00065B, 1'b1, 1'b0, st);
      drain();
      send_pkt(32'h2, 2, 24'h000000, 24'h000000, 24'h000CB6, 1'b1, 1'b0, st);
      drain();
      tog = 1'b0;
      @(posedge aclk);
      #1;
      m_tready = 1'b1;
      @(posedge aclk);
      #1;

      // Reset while CRC bit 10 sits in the output register.
      p0 = pops;
      send_pkt(32'h1, 1, 24'h000000, 24'h000000, 24'h00065B, 1'b0, 1'b0, st);
      t = 0;
      while (pops < p0 + 11 && t < 200) begin
         @(posedge aclk);
         #1;
         t++;
      end
      chk("pre_reset_pops", pops - p0, 32'd11);
      do_reset();
      chk("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("midrst_busy",     {31'd0, busy},     32'd0);
`ifdef BLE_CRC_APPENDER_PKT_COUNT_EN
      chk("midrst_pkt_count", {16'd0, pkt_count}, 32'd0);
`endif
      in_reset = 1'b0;
      repeat (4) begin
         @(posedge aclk);
         #1;
      end
      chk("post_rst_idle", {31'd0, m_tvalid}, 32'd0);
      send_pkt(32'h1, 1, 24'h555555, 24'h555555, 24'hAAACF1, 1'b0, 1'b0, st);
      drain();

      // Back-to-back packets with s_tvalid held high.
      do_reset();
      in_reset = 1'b0;
      send_pkt(32'h1, 1, 24'h000000, 24'h000000, 24'h00065B, 1'b0, 1'b1, st);
      send_pkt(32'h0, 1, 24'h800000, 24'h800000, 24'h00065B, 1'b0, 1'b0, st);
      chk("b2b_stall_cycles", st, 32'd25);
      drain();
`ifdef BLE_CRC_APPENDER_PKT_COUNT_EN
      chk("b2b_pkt_count", {16'd0, pkt_count}, 32'd2);
`endif
      chk("end_busy", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
